// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial pattern transmitter.
// Latches a PAT_LEN-bit pattern on start and shifts it out MSB-first, one bit
// per clock. The pattern repeats max(repeat_count,1) times with GAP_LEN idle
// cycles between repetitions. All outputs are registered.
// Optional build macro SEQTX_PARITY_EN adds one even-parity bit after each
// repetition's LSB.
module seq_pattern_tx #(
    parameter int                 PAT_LEN     = 5,
    parameter logic [PAT_LEN-1:0] DEFAULT_PAT = 5'b11101,
    parameter int                 CNT_W       = 4,
    parameter int                 GAP_LEN     = 0,
    parameter logic               IDLE_BIT    = 1'b0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               use_default,
    input  logic [PAT_LEN-1:0] pattern_in,
    input  logic [CNT_W-1:0]   repeat_count,
    output logic               dataout,
    output logic               valid,
    output logic               busy,
    output logic               done
);

    localparam int IDX_W = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
    localparam int GAP_W = (GAP_LEN > 0) ? $clog2(GAP_LEN + 1) : 1;
    localparam logic [IDX_W-1:0] IDX_LOAD = IDX_W'(PAT_LEN - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_LEN > 0) ? (GAP_LEN - 1) : 0);
    localparam logic [CNT_W-1:0] ONE_REP  = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEND = 3'd1,
        ST_GAP  = 3'd2,
`ifdef SEQTX_PARITY_EN
        ST_PAR  = 3'd3,
`endif
        ST_DONE = 3'd4
    } state_t;

`ifdef SEQTX_PARITY_EN
    // Even parity over the whole pattern: the XOR of all its bits.
    function automatic logic even_parity(input logic [PAT_LEN-1:0] v);
        even_parity = ^v;
    endfunction
`endif

    state_t             state_r, state_nx_s;
    logic [PAT_LEN-1:0] pat_r, pat_nx_s;
    logic [CNT_W-1:0]   reps_r, reps_nx_s;
    logic [IDX_W-1:0]   bit_idx_r, bit_idx_nx_s, idx_dec_s;
    logic [GAP_W-1:0]   gap_cnt_r, gap_cnt_nx_s;
    logic               dataout_r, dataout_nx_s;
    logic               valid_r, valid_nx_s;
    logic               busy_r, busy_nx_s;
    logic               done_r, done_nx_s;

    // Next values taken at the end of a repetition (after LSB or parity bit).
    state_t             rep_state_s;
    logic [CNT_W-1:0]   rep_reps_s;
    logic [IDX_W-1:0]   rep_idx_s;
    logic [GAP_W-1:0]   rep_gap_s;
    logic               rep_data_s;
    logic               rep_valid_s;
    logic               rep_done_s;

    assign idx_dec_s = bit_idx_r - IDX_W'(1);

    // Decide what follows a finished repetition: gap, back-to-back resend, or done.
    always_comb begin
        rep_state_s = ST_DONE;
        rep_reps_s  = reps_r;
        rep_idx_s   = bit_idx_r;
        rep_gap_s   = gap_cnt_r;
        rep_data_s  = IDLE_BIT;
        rep_valid_s = 1'b0;
        rep_done_s  = 1'b0;
        if (reps_r > ONE_REP) begin
            rep_reps_s = reps_r - ONE_REP;
            if (GAP_LEN > 0) begin
                rep_state_s = ST_GAP;
                rep_gap_s   = GAP_LOAD;
            end else begin
                // No gap: next repetition's MSB directly follows this LSB.
                rep_state_s = ST_SEND;
                rep_idx_s   = IDX_LOAD;
                rep_data_s  = pat_r[IDX_LOAD];
                rep_valid_s = 1'b1;
            end
        end else begin
            rep_state_s = ST_DONE;
            rep_done_s  = 1'b1;
        end
    end

    // Next-state and next-output logic; outputs are registered below.
    always_comb begin
        state_nx_s   = state_r;
        pat_nx_s     = pat_r;
        reps_nx_s    = reps_r;
        bit_idx_nx_s = bit_idx_r;
        gap_cnt_nx_s = gap_cnt_r;
        dataout_nx_s = IDLE_BIT;
        valid_nx_s   = 1'b0;
        busy_nx_s    = 1'b0;
        done_nx_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (use_default) begin
                        pat_nx_s = DEFAULT_PAT;
                    end else begin
                        pat_nx_s = pattern_in;
                    end
                    if (repeat_count == {CNT_W{1'b0}}) begin
                        reps_nx_s = ONE_REP;
                    end else begin
                        reps_nx_s = repeat_count;
                    end
                    bit_idx_nx_s = IDX_LOAD;
                    state_nx_s   = ST_SEND;
                    dataout_nx_s = pat_nx_s[IDX_LOAD];
                    valid_nx_s   = 1'b1;
                    busy_nx_s    = 1'b1;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                busy_nx_s = 1'b1;
                if (bit_idx_r != {IDX_W{1'b0}}) begin
                    bit_idx_nx_s = idx_dec_s;
                    dataout_nx_s = pat_r[idx_dec_s];
                    valid_nx_s   = 1'b1;
                end else begin
`ifdef SEQTX_PARITY_EN
                    state_nx_s   = ST_PAR;
                    dataout_nx_s = even_parity(pat_r);
                    valid_nx_s   = 1'b1;
`else
                    state_nx_s   = rep_state_s;
                    reps_nx_s    = rep_reps_s;
                    bit_idx_nx_s = rep_idx_s;
                    gap_cnt_nx_s = rep_gap_s;
                    dataout_nx_s = rep_data_s;
                    valid_nx_s   = rep_valid_s;
                    done_nx_s    = rep_done_s;
`endif
                end
            end
`ifdef SEQTX_PARITY_EN
            ST_PAR: begin
                busy_nx_s    = 1'b1;
                state_nx_s   = rep_state_s;
                reps_nx_s    = rep_reps_s;
                bit_idx_nx_s = rep_idx_s;
                gap_cnt_nx_s = rep_gap_s;
                dataout_nx_s = rep_data_s;
                valid_nx_s   = rep_valid_s;
                done_nx_s    = rep_done_s;
            end
`endif
            ST_GAP: begin
                busy_nx_s = 1'b1;
                if (gap_cnt_r == {GAP_W{1'b0}}) begin
                    state_nx_s   = ST_SEND;
                    bit_idx_nx_s = IDX_LOAD;
                    dataout_nx_s = pat_r[IDX_LOAD];
                    valid_nx_s   = 1'b1;
                end else begin
                    gap_cnt_nx_s = gap_cnt_r - GAP_W'(1);
                end
            end
            ST_DONE: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            pat_r     <= {PAT_LEN{1'b0}};
            reps_r    <= {CNT_W{1'b0}};
            bit_idx_r <= {IDX_W{1'b0}};
            gap_cnt_r <= {GAP_W{1'b0}};
            dataout_r <= IDLE_BIT;
            valid_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            pat_r     <= pat_nx_s;
            reps_r    <= reps_nx_s;
            bit_idx_r <= bit_idx_nx_s;
            gap_cnt_r <= gap_cnt_nx_s;
            dataout_r <= dataout_nx_s;
            valid_r   <= valid_nx_s;
            busy_r    <= busy_nx_s;
            done_r    <= done_nx_s;
        end
    end

    assign dataout = dataout_r;
    assign valid   = valid_r;
    assign busy    = busy_r;
    assign done    = done_r;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: two instances (GAP_LEN=0 and GAP_LEN=2) share
// the stimulus; a per-instance queue holds the expected per-cycle outputs.
module tb_seq_pattern_tx;

    typedef struct packed {
        logic d;
        logic v;
        logic b;
        logic dn;
    } exp_t;

    typedef struct {
        logic       use_def;
        logic [4:0] pat;
        logic [3:0] rc;
        bit         mid_pulse;
        bit         det_chk;
        int         busy0;
        int         busy1;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       use_default = 1'b0;
    logic [4:0] pattern_in = 5'b00000;
    logic [3:0] repeat_count = 4'd0;
    logic       dout0, valid0, busy0, done0;
    logic       dout1, valid1, busy1, done1;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;
    int   busy_tot0 = 0;
    int   busy_tot1 = 0;
    int   det_hits = 0;
    logic [4:0] det_sr = 5'b00000;
    int   par_extra = 0;
    vec_t vecs[6];

    localparam exp_t E_IDLE = 4'b0000;

    always #5 clock = ~clock;

    seq_pattern_tx u_dut0 (
        .clock(clock), .reset(reset), .start(start), .use_default(use_default),
        .pattern_in(pattern_in), .repeat_count(repeat_count),
        .dataout(dout0), .valid(valid0), .busy(busy0), .done(done0)
    );

    seq_pattern_tx #(.GAP_LEN(2)) u_dut1 (
        .clock(clock), .reset(reset), .start(start), .use_default(use_default),
        .pattern_in(pattern_in), .repeat_count(repeat_count),
        .dataout(dout1), .valid(valid1), .busy(busy1), .done(done1)
    );

    task automatic push(input int sel, input exp_t e);
        if (sel == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    // Reference stream: bits MSB-first, optional parity, gaps, then done.
    task automatic model_push(input int sel, input logic [4:0] pat, input int reps, input int gap);
        exp_t e;
        for (int r = 0; r < reps; r++) begin
            for (int b = 4; b >= 0; b--) begin
                e = {pat[b], 1'b1, 1'b1, 1'b0};
                push(sel, e);
            end
`ifdef SEQTX_PARITY_EN
            e = {^pat, 1'b1, 1'b1, 1'b0};
            push(sel, e);
`endif
            if (r < reps - 1) begin
                for (int g = 0; g < gap; g++) push(sel, 4'b0010);
            end
        end
        push(sel, 4'b0011);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0) && n < 500) begin
            @(posedge clock); #1;
            n++;
        end
        if (q0.size() > 0 || q1.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d/%0d entries left, required 0/0", q0.size(), q1.size());
            q0.delete();
            q1.delete();
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic [4:0] p;
        int reps, s0, s1, h0, got0, got1;
        p    = v.use_def ? 5'b11101 : v.pat;
        reps = (v.rc == 4'd0) ? 1 : int'(v.rc);
        s0 = busy_tot0; s1 = busy_tot1; h0 = det_hits;
        @(posedge clock); #1;
        start = 1'b1; use_default = v.use_def; pattern_in = v.pat; repeat_count = v.rc;
        push(0, E_IDLE); push(1, E_IDLE);
        model_push(0, p, reps, 0);
        model_push(1, p, reps, 2);
        push(0, E_IDLE); push(1, E_IDLE);
        @(posedge clock); #1;
        start = 1'b0;
        use_default = ~v.use_def;
        pattern_in = 5'($urandom);
        repeat_count = 4'($urandom);
        if (v.mid_pulse) begin
            @(posedge clock); #1;
            start = 1'b1;
            pattern_in = 5'($urandom);
            @(posedge clock); #1;
            start = 1'b0;
        end
        wait_drain();
        got0 = busy_tot0 - s0;
        got1 = busy_tot1 - s1;
        checks++;
        if (got0 != v.busy0 + par_extra * reps) begin
            errors++;
            $display("FAIL busy_cycles_gap0: got %0d, required %0d", got0, v.busy0 + par_extra * reps);
        end
        checks++;
        if (got1 != v.busy1 + par_extra * reps) begin
            errors++;
            $display("FAIL busy_cycles_gap2: got %0d, required %0d", got1, v.busy1 + par_extra * reps);
        end
        if (v.det_chk) begin
            checks++;
            if (det_hits - h0 != 1) begin
                errors++;
                $display("FAIL detector_hits: got %0d, required 1", det_hits - h0);
            end
        end
    endtask

    // Monitor: pop one expectation per cycle and compare away from the clock edge.
    initial begin
        exp_t e;
        exp_t g;
        forever begin
            @(negedge clock);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                g = {dout0, valid0, busy0, done0};
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL stream_gap0 @%0t: got d/v/b/done=%b, required %b", $time, g, e);
                end
                if (busy0 === 1'b1) busy_tot0++;
                det_sr = {det_sr[3:0], dout0};
                if (det_sr === 5'b11101) det_hits++;
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                g = {dout1, valid1, busy1, done1};
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL stream_gap2 @%0t: got d/v/b/done=%b, required %b", $time, g, e);
                end
                if (busy1 === 1'b1) busy_tot1++;
            end
        end
    end

    initial begin
        int n1;
`ifdef SEQTX_PARITY_EN
        par_extra = 1;
`endif
        vecs[0] = '{1'b1, 5'b00000, 4'd1,  1'b0, 1'b1, 6,  6};
        vecs[1] = '{1'b0, 5'b10110, 4'd3,  1'b1, 1'b0, 16, 20};
        vecs[2] = '{1'b0, 5'b10110, 4'd0,  1'b1, 1'b0, 6,  6};
        vecs[3] = '{1'b0, 5'b01010, 4'd2,  1'b0, 1'b0, 11, 13};
        vecs[4] = '{1'b0, 5'b00001, 4'd4,  1'b1, 1'b0, 21, 27};
        vecs[5] = '{1'b0, 5'b11111, 4'd15, 1'b0, 1'b0, 76, 104};

        // Reset state
        @(posedge clock); #1;
        push(0, E_IDLE); push(1, E_IDLE);
        push(0, E_IDLE); push(1, E_IDLE);
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
        wait_drain();

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // start held high: second transfer accepted after one IDLE cycle
        n1 = 5 + par_extra;
        @(posedge clock); #1;
        start = 1'b1; use_default = 1'b1; repeat_count = 4'd1;
        for (int s = 0; s < 2; s++) begin
            push(0, E_IDLE); push(1, E_IDLE);
            model_push(0, 5'b11101, 1, 0);
            model_push(1, 5'b11101, 1, 2);
        end
        push(0, E_IDLE); push(1, E_IDLE);
        repeat (n1 + 3) @(posedge clock);
        #1;
        start = 1'b0;
        wait_drain();

        // Reset during the 3rd bit aborts with no done pulse
        @(posedge clock); #1;
        start = 1'b1; use_default = 1'b1; repeat_count = 4'd2;
        for (int s = 0; s < 2; s++) begin
            push(s, E_IDLE);
            for (int k = 0; k < 3; k++) push(s, 4'b1110);
            for (int k = 0; k < 3; k++) push(s, E_IDLE);
        end
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        wait_drain();
        run_vec(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
Serial pattern transmitter, the sending end of the team's serial sequence detectors. It latches an N-bit pattern (default 11101) on a start request and shifts it out MSB-first, one bit per clock. The pattern can be repeated with programmable idle gaps between repetitions. It drives the detector's datain directly, for self-test and link stimulus.

Parameters:
PAT_LEN, 5, pattern width in bits (>=2)
DEFAULT_PAT, 5'b11101, pattern used when use_default=1
CNT_W, 4, width of repeat_count
GAP_LEN, 0, idle cycles inserted between repetitions (0 = back-to-back, overlap-style stream)
IDLE_BIT, 1'b0, dataout level when not sending pattern bits

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
start  input  1  request; sampled only in IDLE
use_default  input  1  1 = send DEFAULT_PAT, 0 = send pattern_in; sampled with start
pattern_in  input  PAT_LEN  pattern to send; latched with start
repeat_count  input  CNT_W  number of repetitions; latched with start; 0 treated as 1
dataout  output  1  serial bit (registered)
valid  output  1  1 while dataout carries a pattern or parity bit
busy  output  1  high from the cycle after start acceptance until DONE inclusive
done  output  1  one-cycle pulse after the final bit

Behaviour:
- Reset (synchronous, active-high; clock clock): state=IDLE, dataout=IDLE_BIT, valid=0, busy=0, done=0, internal counters cleared. Reset mid-transfer aborts immediately. done is not pulsed.
- All outputs are registered. Bits are never reordered or dropped.
- States: IDLE, SEND, GAP, PAR (only with the optional feature), DONE.
- IDLE: start=1 at edge E latches the pattern (pattern_in or DEFAULT_PAT), reps=max(repeat_count,1) and bit_idx=PAT_LEN-1. After E: state=SEND, busy=1, valid=1, dataout=pattern[PAT_LEN-1]. Latency from start to the first bit is 1 cycle.
- SEND: one bit per cycle, MSB first, bit_idx decrements. On the last bit (bit_idx=0):
  - PAR is next if the feature is enabled.
  - Otherwise, if reps_left>1: GAP is next when GAP_LEN>0, else SEND with bit_idx reloaded. The first bit of the next repetition directly follows the LSB of the previous one.
  - Otherwise: DONE.
- GAP: GAP_LEN cycles with valid=0 and dataout=IDLE_BIT, then SEND.
- DONE: exactly one cycle with done=1, busy=1, valid=0, dataout=IDLE_BIT. Then IDLE with busy=0.
- start while not in IDLE (including DONE) is ignored. pattern_in, use_default and repeat_count changes after acceptance have no effect.
- Total busy cycles for R reps (no parity): R*PAT_LEN + (R-1)*GAP_LEN + 1.
- Counters are sized to avoid wrap: repetition counter CNT_W bits, bit index clog2(PAT_LEN) bits, gap counter clog2(GAP_LEN+1) bits.
- start held high continuously: a new transfer is accepted in the first IDLE cycle after DONE, giving 1 IDLE cycle between transfers.

Optional Feature:
Macro SEQTX_PARITY_EN.
- Defined: after each repetition's LSB, state PAR emits one even-parity bit (XOR of the latched pattern) with valid=1. Then GAP, SEND or DONE follows as above. Busy cycles per repetition grow by 1.
- Undefined: the PAR state and parity logic are absent. Behaviour is exactly as described without it.

Test Plan:
- Reset, use_default=1, repeat_count=1, start pulse -> dataout 1,1,1,0,1 on the 5 cycles after start, valid=1 on those cycles, done=1 on the 6th cycle, busy low on the 7th.
- Same stream fed to the Moore 11101 overlap detector -> detector dataout=1 exactly once, in the cycle its state reaches the final match with datain=1.
- pattern_in=5'b10110, use_default=0, repeat_count=3, GAP_LEN=2 -> 10110,00,10110,00,10110 with valid=0 during gaps; busy for 20 cycles.
- repeat_count=0 -> identical to repeat_count=1. start pulsed mid-transfer -> ignored, stream unchanged.
- Reset asserted on the 3rd bit -> next cycle dataout=IDLE_BIT, valid=0, busy=0, no done; a fresh start afterwards sends the full pattern.
- SEQTX_PARITY_EN defined, default pattern -> 1,1,1,0,1,0 (parity of 11101 is 0), valid=1 for 6 cycles, done on the 7th.
